// File: rtl/core_seq_pkg.sv
// Shared definitions for the core_seq control sequencer: state encoding,
// RV32I major-opcode constants (also used by the decoder), fault codes and
// the opcode classification used in DECODE.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_IMEM_TO = 2'b10;
  localparam logic [1:0] FC_DMEM_TO = 2'b11;

  typedef enum logic [1:0] {
    CL_ILLEGAL = 2'd0,
    CL_EXEC    = 2'd1,
    CL_MEM     = 2'd2
  } op_class_t;

  // SYSTEM with func3==000 (ECALL/EBREAK/xRET) is not supported by this core.
  function automatic op_class_t classify(input logic [6:0] opc, input logic [2:0] f3);
    op_class_t c;
    c = CL_ILLEGAL;
    unique case (opc)
      OPC_LOAD, OPC_STORE: c = CL_MEM;
      OPC_OPIMM, OPC_OP, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_BRANCH: c = CL_EXEC;
      OPC_SYSTEM: c = (f3 != 3'b000) ? CL_EXEC : CL_ILLEGAL;
      default: c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/core_seq_req_timer.sv
// Memory request time-out counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to zero (state entry)
//   cnt_en   : request outstanding without ack this cycle
//   expired  : count has reached MEM_TIMEOUT-1 (caller qualifies with ack)
// MEM_TIMEOUT=0 removes the counter; expired is then constant 0.
module req_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, rst, clr, cnt_en};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
      logic [CW-1:0] cnt;

      // Count stops at LAST; the sequencer leaves the state on that cycle.
      always_ff @(posedge clk) begin
        if (rst || clr)                cnt <= '0;
        else if (cnt_en && cnt != LAST) cnt <= cnt + 1'b1;
      end

      assign expired = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/core_seq.sv
// Multi-cycle control sequencer for the single-issue RV32I core.
// FETCH -> DECODE -> EXEC|MEM -> FETCH, with a sticky FAULT state.
//   run/opcode/func3/alu_cmp   : start permit, IR fields, branch condition
//   imem_req/imem_ack/ir_we    : instruction fetch handshake, IR load
//   dmem_req/dmem_we/dmem_ack  : data access handshake
//   reg_we/csr_we/pc_we/pc_branch : one-cycle write strobes
//   retired                    : retired count (wraps)
//   fault/fault_code           : sticky fault and its cause
module core_seq
  import core_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             alu_cmp,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             reg_we,
  output logic             csr_we,
  output logic             pc_we,
  output logic             pc_branch,
  output logic [RET_W-1:0] retired,
  output logic             fault,
  output logic [1:0]       fault_code
);

  state_t           state, state_n;
  logic [1:0]       code_q, code_n;
  logic [RET_W-1:0] ret_q;
  logic             fetch_hold;   // fetch request already raised, awaiting ack
  logic             freq;
  logic             retire;
  logic             tmr_clr, tmr_cnt, tmr_exp;
  op_class_t        cls;

  assign cls = classify(opcode, func3);

  req_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .cnt_en  (tmr_cnt),
    .expired (tmr_exp)
  );

  // Any state change restarts the timer, so it is zero on entry to FETCH/MEM.
  assign tmr_clr = (state_n != state);

  always_comb begin
    state_n   = state;
    code_n    = code_q;
    freq      = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    csr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_branch = 1'b0;
    retire    = 1'b0;
    tmr_cnt   = 1'b0;
    unique case (state)
      ST_FETCH: begin
        freq     = run | fetch_hold;
        imem_req = freq;
        if (freq && imem_ack) begin
          ir_we   = 1'b1;
          state_n = ST_DECODE;
        end else if (freq) begin
          tmr_cnt = 1'b1;
          if (tmr_exp) begin
            state_n = ST_FAULT;
            code_n  = FC_IMEM_TO;
          end
        end
      end
      ST_DECODE: begin
        unique case (cls)
          CL_MEM:  state_n = ST_MEM;
          CL_EXEC: state_n = ST_EXEC;
          default: begin
            state_n = ST_FAULT;
            code_n  = FC_ILLEGAL;
          end
        endcase
      end
      ST_EXEC: begin
        pc_we     = 1'b1;
        reg_we    = (opcode != OPC_BRANCH);
        csr_we    = (opcode == OPC_SYSTEM);
        pc_branch = (opcode == OPC_BRANCH) & alu_cmp;
        retire    = 1'b1;
        state_n   = ST_FETCH;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OPC_STORE);
        if (dmem_ack) begin
          pc_we   = 1'b1;
          reg_we  = (opcode == OPC_LOAD);
          retire  = 1'b1;
          state_n = ST_FETCH;
        end else begin
          tmr_cnt = 1'b1;
          if (tmr_exp) begin
            state_n = ST_FAULT;
            code_n  = FC_DMEM_TO;
          end
        end
      end
      ST_FAULT: state_n = ST_FAULT;
      default: begin
        state_n = ST_FAULT;
        code_n  = FC_ILLEGAL;
      end
    endcase
    // Requests and strobes must be quiet while reset is asserted.
    if (rst) begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_we    = 1'b0;
      csr_we    = 1'b0;
      pc_we     = 1'b0;
      pc_branch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FETCH;
      code_q     <= FC_NONE;
      ret_q      <= '0;
      fetch_hold <= 1'b0;
    end else begin
      state      <= state_n;
      code_q     <= code_n;
      fetch_hold <= freq & ~imem_ack;
      if (retire) ret_q <= ret_q + RET_W'(1);
    end
  end

  assign retired    = ret_q;
  assign fault      = (state == ST_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq. Two instances share all inputs: A (MEM_TIMEOUT=16,
// RET_W=32) and B (MEM_TIMEOUT=4, RET_W=4, exercises wrap). The stimulus is
// a per-instruction script (idle cycles, fetch delay, opcode, mem delay); the
// expected output trace is derived from that script with the instruction
// latency rules, and B simply parks in fault when its shorter time-out hits.
module tb_core_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, alu_cmp, imem_ack, dmem_ack;
  logic [6:0] opcode;
  logic [2:0] func3;

  logic a_imem_req, a_ir_we, a_dmem_req, a_dmem_we, a_reg_we, a_csr_we, a_pc_we, a_pc_branch, a_fault;
  logic b_imem_req, b_ir_we, b_dmem_req, b_dmem_we, b_reg_we, b_csr_we, b_pc_we, b_pc_branch, b_fault;
  logic [31:0] a_retired;
  logic [3:0]  b_retired;
  logic [1:0]  a_fault_code, b_fault_code;

  core_seq #(.MEM_TIMEOUT(16), .RET_W(32)) dut_a (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func3(func3), .alu_cmp(alu_cmp),
    .imem_req(a_imem_req), .imem_ack(imem_ack), .ir_we(a_ir_we),
    .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_ack(dmem_ack),
    .reg_we(a_reg_we), .csr_we(a_csr_we), .pc_we(a_pc_we), .pc_branch(a_pc_branch),
    .retired(a_retired), .fault(a_fault), .fault_code(a_fault_code));

  core_seq #(.MEM_TIMEOUT(4), .RET_W(4)) dut_b (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func3(func3), .alu_cmp(alu_cmp),
    .imem_req(b_imem_req), .imem_ack(imem_ack), .ir_we(b_ir_we),
    .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_ack(dmem_ack),
    .reg_we(b_reg_we), .csr_we(b_csr_we), .pc_we(b_pc_we), .pc_branch(b_pc_branch),
    .retired(b_retired), .fault(b_fault), .fault_code(b_fault_code));

  // [10]imem_req [9]ir_we [8]dmem_req [7]dmem_we [6]reg_we [5]csr_we
  // [4]pc_we [3]pc_branch [2]fault [1:0]fault_code
  logic [10:0] act_a, act_b;
  assign act_a = {a_imem_req, a_ir_we, a_dmem_req, a_dmem_we, a_reg_we, a_csr_we,
                  a_pc_we, a_pc_branch, a_fault, a_fault_code};
  assign act_b = {b_imem_req, b_ir_we, b_dmem_req, b_dmem_we, b_reg_we, b_csr_we,
                  b_pc_we, b_pc_branch, b_fault, b_fault_code};

  int tests = 0;
  int fails = 0;

  // Model state per instance (0 = A, 1 = B)
  bit          alive [2];
  logic [1:0]  fcode [2];
  logic [31:0] ret   [2];
  logic [10:0] exp_o [2];
  logic [31:0] exp_r [2];
  bit          chk_en = 1'b0;
  bit          strobe_only = 1'b0;

  function automatic int tmo(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic logic [10:0] ov(input bit ireq, input bit iwe, input bit dreq, input bit dwe,
                                     input bit rwe, input bit cwe, input bit pwe, input bit pb);
    return {ireq, iwe, dreq, dwe, rwe, cwe, pwe, pb, 3'b000};
  endfunction

  // 0 illegal, 1 exec, 2 mem
  function automatic int op_kind(input logic [6:0] o, input logic [2:0] f);
    case (o)
      7'b0000011, 7'b0100011: return 2;
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111, 7'b1100011: return 1;
      7'b1110011: return (f != 3'b000) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Single compare process: every checked cycle, both instances.
  logic [10:0] cmp_o;
  logic [31:0] cmp_r;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        cmp_o = (k == 0) ? act_a : act_b;
        cmp_r = (k == 0) ? a_retired : {28'd0, b_retired};
        tests++;
        if (strobe_only) begin
          if (cmp_o[10:3] !== exp_o[k][10:3]) begin
            fails++;
            $display("FAIL reset_strobes dut%0d t=%0t got %b want %b", k, $time, cmp_o[10:3], exp_o[k][10:3]);
          end
        end else if (cmp_o !== exp_o[k] || cmp_r !== exp_r[k]) begin
          fails++;
          $display("FAIL cycle dut%0d t=%0t got outs=%b ret=%0d want outs=%b ret=%0d",
                   k, $time, cmp_o, cmp_r, exp_o[k], exp_r[k]);
        end
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One clock cycle: caller has set run/opcode/func3/alu_cmp.
  task automatic cyc(input bit r, input bit ia, input bit da, input logic [10:0] live);
    rst = r; imem_ack = ia; dmem_ack = da;
    for (int k = 0; k < 2; k++) begin
      exp_o[k] = alive[k] ? live : {8'd0, 1'b1, fcode[k]};
      exp_r[k] = ret[k];
    end
    chk_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rand_side();
    run = 1'($urandom); opcode = 7'($urandom); func3 = 3'($urandom); alu_cmp = 1'($urandom);
  endtask

  task automatic retire_alive();
    for (int k = 0; k < 2; k++)
      if (alive[k]) ret[k] = (k == 0) ? ret[k] + 1 : ((ret[k] + 1) & 32'hF);
  endtask

  task automatic kill_expired(input int n, input bit ack, input logic [1:0] code);
    for (int k = 0; k < 2; k++)
      if (alive[k] && !ack && n == tmo(k) - 1) begin
        alive[k] = 1'b0;
        fcode[k] = code;
      end
  endtask

  task automatic do_reset();
    rand_side();
    strobe_only = 1'b1;
    cyc(1'b1, 1'($urandom), 1'($urandom), 11'd0);  // register values still old here
    strobe_only = 1'b0;
    for (int k = 0; k < 2; k++) begin
      alive[k] = 1'b1; fcode[k] = 2'b00; ret[k] = 32'd0;
    end
    rand_side();
    cyc(1'b1, 1'($urandom), 1'($urandom), 11'd0);
  endtask

  task automatic fault_idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_side();
      cyc(1'b0, 1'($urandom), 1'($urandom), 11'd0);
    end
  endtask

  // cmp < 0 : random alu_cmp in EXEC
  task automatic run_instr(input int idle, input int fd, input logic [6:0] opc, input logic [2:0] f3,
                           input int md, input bit run_rand, input int cmp);
    bit ack, br, sys;
    int kind;
    for (int i = 0; i < idle; i++) begin
      rand_side(); run = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; ; i++) begin
      rand_side();
      run = (i == 0) ? 1'b1 : (run_rand ? 1'($urandom) : 1'b1);
      ack = (i == fd);
      cyc(1'b0, ack, 1'b0, ov(1, ack, 0, 0, 0, 0, 0, 0));
      kill_expired(i, ack, 2'b10);
      if (ack || !alive[0]) break;
    end
    if (!alive[0]) return;
    rand_side(); opcode = opc; func3 = f3;
    cyc(1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0));
    kind = op_kind(opc, f3);
    if (kind == 0) begin
      for (int k = 0; k < 2; k++)
        if (alive[k]) begin alive[k] = 1'b0; fcode[k] = 2'b01; end
      return;
    end
    if (kind == 1) begin
      run = 1'($urandom);
      alu_cmp = (cmp < 0) ? 1'($urandom) : 1'(cmp);
      br  = (opc == 7'b1100011);
      sys = (opc == 7'b1110011);
      cyc(1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, !br, sys, 1, br && alu_cmp));
      retire_alive();
      return;
    end
    for (int j = 0; ; j++) begin
      run = 1'($urandom); alu_cmp = 1'($urandom);
      ack = (j == md);
      cyc(1'b0, 1'b0, ack, ov(0, 0, 1, opc == 7'b0100011, ack && opc == 7'b0000011, 0, ack, 0));
      if (ack) retire_alive();
      kill_expired(j, ack, 2'b11);
      if (ack || !alive[0]) break;
    end
  endtask

  logic [6:0] legal_ops [10];
  logic [6:0] opc;
  int r, fd, md;

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111,
                  7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011};
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; rand_side();
    for (int k = 0; k < 2; k++) begin
      alive[k] = 1'b1; fcode[k] = 2'b00; ret[k] = 32'd0;
    end
    @(posedge clk); #1;
    do_reset();
    check_lit("reset_fault", {31'd0, a_fault}, 32'd0);

    // ADDI, ack on first request cycle; next run_instr checks re-raise.
    run_instr(0, 0, 7'b0010011, 3'b000, 0, 1'b0, -1);
    check_lit("addi_retired", a_retired, 32'd1);
    // BEQ taken then not taken
    run_instr(0, 0, 7'b1100011, 3'b000, 0, 1'b0, 1);
    run_instr(0, 1, 7'b1100011, 3'b000, 0, 1'b0, 0);
    // LW with 5-cycle ack delay: B times out, A completes
    run_instr(1, 0, 7'b0000011, 3'b010, 5, 1'b0, -1);
    check_lit("lw_retired_a", a_retired, 32'd4);
    check_lit("lw_fault_code_b", {30'd0, b_fault_code}, 32'd3);
    do_reset();
    // SW with run toggling mid-fetch
    run_instr(0, 3, 7'b0100011, 3'b010, 2, 1'b1, -1);
    check_lit("sw_retired_b", {28'd0, b_retired}, 32'd1);
    // Illegal opcodes
    run_instr(0, 0, 7'b0000000, 3'b000, 0, 1'b0, -1);
    fault_idle(3);
    check_lit("illegal0_code", {30'd0, a_fault_code}, 32'd1);
    do_reset();
    check_lit("post_reset_fault", {31'd0, a_fault}, 32'd0);
    run_instr(0, 0, 7'b1110011, 3'b000, 0, 1'b0, -1);
    fault_idle(2);
    check_lit("ecall_code", {30'd0, b_fault_code}, 32'd1);
    do_reset();
    // CSR op retires with csr_we
    run_instr(0, 0, 7'b1110011, 3'b001, 0, 1'b0, -1);
    // Fetch time-out: B after 4 request cycles, A after 16
    run_instr(0, 40, 7'b0010011, 3'b000, 0, 1'b0, -1);
    check_lit("imem_to_code_b", {30'd0, b_fault_code}, 32'd2);
    check_lit("imem_to_code_a", {30'd0, a_fault_code}, 32'd2);
    do_reset();
    // Ack on the 4th request cycle wins over B's time-out
    run_instr(0, 3, 7'b0010011, 3'b000, 0, 1'b0, -1);
    check_lit("ack_wins_fault_b", {31'd0, b_fault}, 32'd0);
    // Data time-out on both
    run_instr(0, 0, 7'b0100011, 3'b000, 40, 1'b0, -1);
    check_lit("dmem_to_code_a", {30'd0, a_fault_code}, 32'd3);
    do_reset();
    // Reset mid-request
    rand_side(); run = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, ov(1, 0, 0, 0, 0, 0, 0, 0));
    kill_expired(0, 1'b0, 2'b10);
    rand_side();
    cyc(1'b0, 1'b0, 1'b0, ov(1, 0, 0, 0, 0, 0, 0, 0));
    kill_expired(1, 1'b0, 2'b10);
    do_reset();

    // Randomized program
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r < 18)       opc = legal_ops[r % 10];
      else if (r == 18) opc = 7'($urandom);
      else              opc = 7'b1110011;
      r  = $urandom_range(0, 31);
      fd = (r < 26) ? $urandom_range(0, 2) : (r < 31) ? $urandom_range(3, 6) : $urandom_range(15, 18);
      r  = $urandom_range(0, 31);
      md = (r < 26) ? $urandom_range(0, 2) : (r < 31) ? $urandom_range(3, 6) : $urandom_range(15, 18);
      run_instr($urandom_range(0, 2), fd, opc, (opc == 7'b1110011 && r[0]) ? 3'b000 : 3'($urandom),
                md, 1'b1, -1);
      if (!alive[0]) begin
        fault_idle($urandom_range(1, 3));
        do_reset();
      end else if (!alive[1] && $urandom_range(0, 3) == 0) begin
        do_reset();
      end
    end

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
